phi_weighted_combiner: RTL

- Consumer of the packed trigonometric functional-expansion vector: computes the FLAF filter output y = sum over k of phi[k]*w[k], for k = 0..Q_ORD-1.
- Time-multiplexed: a single signed multiplier-accumulator walks the Q_ORD branches serially.
- Upstream is the Phi map expansion stage. Downstream is the error/weight-update path.
- Valid/ready handshake on input; one-cycle valid pulse on output.

---
 rtl/phi_weighted_combiner_if.sv | 24 ++
 rtl/phi_weighted_combiner.sv | 122 ++++++++++++
 2 files changed

// File: rtl/phi_weighted_combiner_if.sv
// Handshake bundle between the Phi expansion stage, the weighted combiner and the
// error/weight-update path.
interface phi_weighted_combiner_if #(
    parameter int unsigned Q_ORD = 7,
    parameter int unsigned WIDTH = 16
);
    logic                     phi_valid;
    logic                     phi_ready;
    logic [Q_ORD*WIDTH-1:0]   phi_packed;
    logic [Q_ORD*WIDTH-1:0]   w_packed;
    logic [WIDTH-1:0]         y_out;
    logic                     y_valid;
    logic                     busy;

    modport master (
        output phi_valid, phi_packed, w_packed,
        input  phi_ready, y_out, y_valid, busy
    );

    modport slave (
        input  phi_valid, phi_packed, w_packed,
        output phi_ready, y_out, y_valid, busy
    );
endinterface

// File: rtl/phi_weighted_combiner.sv
// Serial FLAF combiner: y = sum phi[k]*w[k] over Q_ORD branches with one signed MAC.
// Define PHI_COMBINER_SAT_EN to clamp the rounded result instead of wrapping it.
module phi_weighted_combiner #(
    parameter int unsigned Q_ORD  = 7,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned PHI_QP = 15,
    parameter int unsigned WQP    = 12,
    parameter int unsigned ACC_W  = 2 * WIDTH + 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    phi_weighted_combiner_if.slave bus_io
);
    localparam int unsigned CntW = (Q_ORD > 1) ? $clog2(Q_ORD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Q_ORD - 1);
    localparam logic signed [ACC_W-1:0] RndHalf = ACC_W'(1) << (PHI_QP - 1);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                   state_q;
    logic [CntW-1:0]          cnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [Q_ORD*WIDTH-1:0]   phi_q;
    logic [Q_ORD*WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]         y_q;
    logic                     y_valid_q;
    logic                     phi_ready_q;
    logic                     busy_q;

    logic signed [WIDTH-1:0]   phi_k;
    logic signed [WIDTH-1:0]   w_k;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   rounded;
    logic [WIDTH-1:0]          y_red;

    always_comb begin
        phi_k   = phi_q[cnt_q*WIDTH +: WIDTH];
        w_k     = w_q[cnt_q*WIDTH +: WIDTH];
        prod    = phi_k * w_k;
        acc_sum = acc_q + {{(ACC_W - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
        // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
        rounded = (acc_sum + RndHalf) >>> PHI_QP;
    end

`ifdef PHI_COMBINER_SAT_EN
    localparam logic signed [ACC_W-1:0] YMax = (ACC_W'(1) << (WIDTH - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] YMin = ~YMax;

    always_comb begin
        if (rounded > YMax) begin
            y_red = YMax[WIDTH-1:0];
        end else if (rounded < YMin) begin
            y_red = YMin[WIDTH-1:0];
        end else begin
            y_red = rounded[WIDTH-1:0];
        end
    end
`else
    assign y_red = rounded[WIDTH-1:0];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            phi_q       <= '0;
            w_q         <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            phi_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    y_valid_q <= 1'b0;
                    if (bus_io.phi_valid && phi_ready_q) begin
                        phi_q       <= bus_io.phi_packed;
                        w_q         <= bus_io.w_packed;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        phi_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StMac;
                    end else begin
                        phi_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                StMac: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + CntW'(1);
                    // Result is registered on the last MAC edge so y_valid lines up with OUT.
                    if (cnt_q == CntLast) begin
                        y_q       <= y_red;
                        y_valid_q <= 1'b1;
                        state_q   <= StOut;
                    end
                end
                StOut: begin
                    y_valid_q   <= 1'b0;
                    phi_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q     <= StIdle;
                    phi_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    y_valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.phi_ready = phi_ready_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.y_out     = y_q;
    assign bus_io.y_valid   = y_valid_q;
endmodule
